// File: rtl/hilo_pkg.sv
// ============================================================================
//  Module   : hilo_pkg
//  Purpose  : Shared types and decode helpers for the HI/LO unit. Holds the
//             instruction class encoding, the multiplier mode encoding, the
//             FSM state type and the op -> (is_mul, sign, mode) decoders.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hilo_pkg;

  typedef enum logic [3:0] {
    HILO_NOP = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    MADD     = 4'd3,
    MADDU    = 4'd4,
    MSUB     = 4'd5,
    MSUBU    = 4'd6,
    MTHI     = 4'd7,
    MTLO     = 4'd8
  } hilo_op_t;

  typedef enum logic [1:0] {
    MUL_PLAIN = 2'b00,
    MUL_ADD   = 2'b01,
    MUL_SUB   = 2'b10
  } mul_mode_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hilo_state_t;

  // True for every op that needs the multiplier.
  function automatic logic is_mul_op(hilo_op_t op);
    case (op)
      MULT, MULTU, MADD, MADDU, MSUB, MSUBU: is_mul_op = 1'b1;
      default:                               is_mul_op = 1'b0;
    endcase
  endfunction

  // 1 = signed operands.
  function automatic logic op_sign(hilo_op_t op);
    case (op)
      MULT, MADD, MSUB: op_sign = 1'b1;
      default:          op_sign = 1'b0;
    endcase
  endfunction

  function automatic mul_mode_t op_mode(hilo_op_t op);
    case (op)
      MADD, MADDU: op_mode = MUL_ADD;
      MSUB, MSUBU: op_mode = MUL_SUB;
      default:     op_mode = MUL_PLAIN;
    endcase
  endfunction

endpackage : hilo_pkg

`default_nettype wire

// File: rtl/hilo_unit.sv
// ============================================================================
//  Module   : hilo_unit
//  Purpose  : HI/LO architectural register pair and multiply issue controller
//             for the EX stage. Accepts a mul-class op, latches its operands,
//             holds the multiplier inputs steady while BUSY, stalls IF..EX
//             until the multiplier returns a result and then commits HI/LO.
//             MTHI/MTLO write directly in IDLE without stalling.
//  Ports    : clk, rst (sync, active-low)
//             op_valid, op[3:0], rs_val, rt_val, flush   - from EX
//             stall                                       - pipeline hold
//             hi_o, lo_o                                  - architectural HI/LO
//             mul_valid, mul_sign, mul_mode, mul_srca/b,
//             mul_in_hi/lo                                - to multiplier
//             mul_out_valid, mul_hi, mul_lo               - from multiplier
//             timeout_err                                 - sticky watchdog flag
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int WDOG_SLACK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_valid,
  output logic        mul_sign,
  output logic [1:0]  mul_mode,
  output logic [31:0] mul_srca,
  output logic [31:0] mul_srcb,
  output logic [31:0] mul_in_hi,
  output logic [31:0] mul_in_lo,
  input  logic        mul_out_valid,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        timeout_err
);

  // The watchdog gives up after this many BUSY cycles without a result.
  localparam logic [4:0] c_wdog_last = 5'(MUL_CYCLES + 2 + WDOG_SLACK - 1);

  hilo_state_t state_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] srca_q, srcb_q;
  logic        sign_q;
  mul_mode_t   mode_q;
  logic        mul_valid_q;
  logic [4:0]  wdog_q;
  logic        timeout_q;

  hilo_op_t w_op;
  logic     w_idle_op;
  logic     w_accept;
  logic     w_busy_wait;

  assign w_op        = hilo_op_t'(op);
  // flush kills the EX instruction, so it suppresses every IDLE action.
  assign w_idle_op   = op_valid && !flush && (state_q == ST_IDLE);
  assign w_accept    = w_idle_op && is_mul_op(w_op);
  assign w_busy_wait = (state_q == ST_BUSY) && !flush && !mul_out_valid;

  // Gated by rst so the pipeline is never held while the unit is in reset.
  assign stall = rst && (w_accept || w_busy_wait);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      sign_q      <= 1'b0;
      mode_q      <= MUL_PLAIN;
      mul_valid_q <= 1'b0;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            state_q     <= ST_BUSY;
            mul_valid_q <= 1'b1;
            srca_q      <= rs_val;
            srcb_q      <= rt_val;
            sign_q      <= op_sign(w_op);
            mode_q      <= op_mode(w_op);
            wdog_q      <= '0;
          end else if (w_idle_op && (w_op == MTHI)) begin
            hi_q <= rs_val;
          end else if (w_idle_op && (w_op == MTLO)) begin
            lo_q <= rs_val;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            // Abort without commit, even if the result arrives this cycle.
            state_q     <= ST_IDLE;
            mul_valid_q <= 1'b0;
          end else if (mul_out_valid) begin
            hi_q        <= mul_hi;
            lo_q        <= mul_lo;
            state_q     <= ST_IDLE;
            mul_valid_q <= 1'b0;
          end else if (wdog_q >= c_wdog_last) begin
            timeout_q   <= 1'b1;
            state_q     <= ST_IDLE;
            mul_valid_q <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 5'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          mul_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign mul_valid   = mul_valid_q;
  assign mul_sign    = sign_q;
  assign mul_mode    = mode_q;
  assign mul_srca    = srca_q;
  assign mul_srcb    = srcb_q;
  assign mul_in_hi   = hi_q;
  assign mul_in_lo   = lo_q;
  assign timeout_err = timeout_q;

endmodule : hilo_unit

`default_nettype wire

// File: tb/tb_hilo_unit.sv
// ============================================================================
//  Module   : tb_hilo_unit
//  Purpose  : Directed self-checking bench for hilo_unit. Provides a simple
//             multiplier model whose result appears after it has seen
//             in_valid for CYCLES+1 cycles (plain) or CYCLES+3 (accumulate).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_unit;

  localparam int MCYC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        flush;
  logic        stall;
  logic [31:0] hi_o, lo_o;
  logic        mul_valid, mul_sign;
  logic [1:0]  mul_mode;
  logic [31:0] mul_srca, mul_srcb, mul_in_hi, mul_in_lo;
  logic        mul_out_valid;
  logic [31:0] mul_hi, mul_lo;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  hilo_unit #(.MUL_CYCLES(MCYC), .WDOG_SLACK(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
    .hi_o(hi_o), .lo_o(lo_o), .mul_valid(mul_valid), .mul_sign(mul_sign),
    .mul_mode(mul_mode), .mul_srca(mul_srca), .mul_srcb(mul_srcb),
    .mul_in_hi(mul_in_hi), .mul_in_lo(mul_in_lo),
    .mul_out_valid(mul_out_valid), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ---------------- multiplier model ----------------
  logic        stub_dead = 1'b0;
  logic [4:0]  m_cnt = '0;
  logic [63:0] m_prod, m_acc, m_res;

  always @(posedge clk) m_cnt <= mul_valid ? m_cnt + 5'd1 : 5'd0;

  always_comb begin
    m_prod = mul_sign ? ({{32{mul_srca[31]}}, mul_srca} * {{32{mul_srcb[31]}}, mul_srcb})
                      : ({32'd0, mul_srca} * {32'd0, mul_srcb});
    m_acc  = {mul_in_hi, mul_in_lo};
    case (mul_mode)
      2'b01:   m_res = m_acc + m_prod;
      2'b10:   m_res = m_acc - m_prod;
      default: m_res = m_prod;
    endcase
  end

  assign mul_hi = m_res[63:32];
  assign mul_lo = m_res[31:0];
  assign mul_out_valid = mul_valid && !stub_dead &&
                         (m_cnt == ((mul_mode == 2'b00) ? 5'(MCYC + 1) : 5'(MCYC + 3)));

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left 1 time unit after a rising edge. Counts stalled cycles
  // from accept to commit, and BUSY cycles where the multiplier inputs were
  // not steady at the expected mode/sign.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] em, input logic es,
                       output int ns, output int bad, output logic fmv);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    ns = 0; bad = 0; fmv = 1'bx;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (i == 0) fmv = mul_valid;
      if (i > 0 && (mul_valid !== 1'b1 || mul_mode !== em || mul_sign !== es)) bad++;
      if (!stall) break;
      ns++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
  endtask

  task automatic do_mt(input logic [3:0] o, input logic [31:0] a);
    op_valid = 1'b1; op = o; rs_val = a;
    #1;
    chk("mt_no_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
  endtask

  int   ns, bad, n;
  logic fmv;

  initial begin
    rst = 1'b0; op_valid = 1'b0; op = 4'd0; rs_val = '0; rt_val = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
    rst = 1'b1;

    // 1: signed MULT -3 * 5
    do_op(4'd1, 32'hFFFFFFFD, 32'h5, 2'b00, 1'b1, ns, bad, fmv);
    chk("mult_stall_cycles", 64'(ns), 64'd5);
    chk("mult_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
    chk("mult_inputs_steady", 64'(bad), 64'd0);

    // 2: MULTU FFFFFFFF * 2
    do_op(4'd2, 32'hFFFFFFFF, 32'h2, 2'b00, 1'b0, ns, bad, fmv);
    chk("multu_stall_cycles", 64'(ns), 64'd5);
    chk("multu_hilo", {hi_o, lo_o}, 64'h00000001_FFFFFFFE);
    chk("multu_unsigned_steady", 64'(bad), 64'd0);

    // 3: MTHI/MTLO then MADD
    do_mt(4'd7, 32'h0);
    chk("mthi_hi", {32'd0, hi_o}, 64'h0);
    do_mt(4'd8, 32'hA);
    chk("mtlo_lo", {32'd0, lo_o}, 64'hA);
    do_op(4'd3, 32'h4, 32'h5, 2'b01, 1'b1, ns, bad, fmv);
    chk("madd_stall_cycles", 64'(ns), 64'd7);
    chk("madd_hilo", {hi_o, lo_o}, 64'h00000000_0000001E);
    chk("madd_mode_steady", 64'(bad), 64'd0);

    // 4: MSUBU from zero, then back-to-back MULT
    do_mt(4'd7, 32'h0);
    do_mt(4'd8, 32'h0);
    do_op(4'd6, 32'h1, 32'h1, 2'b10, 1'b0, ns, bad, fmv);
    chk("msubu_stall_cycles", 64'(ns), 64'd7);
    chk("msubu_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);
    chk("msubu_mode_steady", 64'(bad), 64'd0);
    do_op(4'd1, 32'h7, 32'h6, 2'b00, 1'b1, ns, bad, fmv);
    chk("b2b_gap_low", {63'd0, fmv}, 64'd0);
    chk("b2b_gap_one_cycle", 64'(bad), 64'd0);
    chk("b2b_stall_cycles", 64'(ns), 64'd5);
    chk("b2b_hilo", {hi_o, lo_o}, 64'h00000000_0000002A);

    // 5a: flush on BUSY cycle 2
    op_valid = 1'b1; op = 4'd1; rs_val = 32'h3; rt_val = 32'h3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    chk("flush_busy_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = 4'd0;
    #1;
    chk("flush_busy_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("flush_busy_hilo", {hi_o, lo_o}, 64'h00000000_0000002A);
    @(posedge clk); #1;

    // 5b: flush on the result cycle
    op_valid = 1'b1; op = 4'd1; rs_val = 32'h3; rt_val = 32'h3;
    for (int i = 0; i < 40 && !mul_out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("flush_res_outv_seen", {63'd0, mul_out_valid}, 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_res_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = 4'd0;
    #1;
    chk("flush_res_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("flush_res_hilo", {hi_o, lo_o}, 64'h00000000_0000002A);
    @(posedge clk); #1;

    // 6: multiplier never answers -> watchdog
    stub_dead = 1'b1;
    op_valid = 1'b1; op = 4'd1; rs_val = 32'h2; rt_val = 32'h2;
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!mul_valid) break;
      n++;
      @(posedge clk); #1;
    end
    op_valid = 1'b0; op = 4'd0;
    #1;
    chk("wdog_busy_cycles", 64'(n), 64'd9);
    chk("wdog_timeout_err", {63'd0, timeout_err}, 64'd1);
    chk("wdog_idle_no_stall", {63'd0, stall}, 64'd0);
    chk("wdog_hilo", {hi_o, lo_o}, 64'h00000000_0000002A);
    @(posedge clk); #1;

    // reset in the middle of BUSY
    op_valid = 1'b1; op = 4'd3; rs_val = 32'h5; rt_val = 32'h5;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("midrst_busy", {63'd0, mul_valid}, 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_stall", {63'd0, stall}, 64'd0);
    chk("midrst_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    chk("midrst_timeout", {63'd0, timeout_err}, 64'd0);
    chk("midrst_srcab", {mul_srca, mul_srcb}, 64'd0);
    chk("midrst_sign_mode", {61'd0, mul_sign, mul_mode}, 64'd0);
    rst = 1'b1; op_valid = 1'b0; op = 4'd0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hilo_unit

`default_nettype wire
